sdram_arbit_mc: RTL

Parametrised multi-channel SDRAM command arbiter; successor to the single read/single write controller arbiter. Sits between the init sequencer, the auto-refresh generator and NUM_CH generic read/write client engines, and the SDRAM pins. Gates all traffic until init completes, gives refresh strict priority, round-robins among clients with sticky request capture, and has a per-grant watchdog. All pin outputs are registered.

---
 rtl/sdram_arbit_mc.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/sdram_arbit_mc.sv
// SDRAM command arbiter: gates traffic until init completes, gives refresh strict priority,
// round-robins NUM_CH client engines with sticky requests, and bounds each grant with a watchdog.
module sdram_arbit_mc #(
  parameter int NUM_CH   = 4,
  parameter int ADDR_W   = 13,
  parameter int BA_W     = 2,
  parameter int DQ_W     = 16,
  parameter int WDOG_CYC = 1024
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     init_end_i,
  input  logic [3:0]               init_cmd_i,
  input  logic [BA_W-1:0]          init_ba_i,
  input  logic [ADDR_W-1:0]        init_addr_i,
  input  logic                     aref_req_i,
  input  logic                     aref_end_i,
  input  logic [3:0]               aref_cmd_i,
  input  logic [BA_W-1:0]          aref_ba_i,
  input  logic [ADDR_W-1:0]        aref_addr_i,
  input  logic [NUM_CH-1:0]        ch_req_i,
  input  logic [NUM_CH-1:0]        ch_end_i,
  input  logic [4*NUM_CH-1:0]      ch_cmd_i,
  input  logic [BA_W*NUM_CH-1:0]   ch_ba_i,
  input  logic [ADDR_W*NUM_CH-1:0] ch_addr_i,
  input  logic [DQ_W*NUM_CH-1:0]   ch_data_i,
  input  logic [NUM_CH-1:0]        ch_dq_en_i,
  output logic                     aref_en_o,
  output logic [NUM_CH-1:0]        ch_en_o,
  output logic                     wdog_err_o,
  output logic                     sdram_cke_o,
  output logic                     sdram_cs_n_o,
  output logic                     sdram_ras_n_o,
  output logic                     sdram_cas_n_o,
  output logic                     sdram_we_n_o,
  output logic [BA_W-1:0]          sdram_ba_o,
  output logic [ADDR_W-1:0]        sdram_addr_o,
  output logic [DQ_W-1:0]          sdram_dq_o,
  output logic                     sdram_dq_oe_o
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WD_W = (WDOG_CYC > 2) ? $clog2(WDOG_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYC - 1);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);
  localparam logic [3:0] CMD_NOP = 4'b0111;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_AREF, S_CH} state_t;

  state_t            state;
  logic [CH_W-1:0]   cur_ch;
  logic [CH_W-1:0]   rr_ptr;
  logic              aref_pend;
  logic [NUM_CH-1:0] ch_pend;
  logic [WD_W-1:0]   wdog_cnt;

  logic              aref_pend_nxt;
  logic [NUM_CH-1:0] ch_pend_nxt;
  logic              rr_found;
  logic [CH_W-1:0]   rr_sel;
  logic [CH_W-1:0]   rr_next;
  logic [CH_W:0]     rr_idx;
  logic              ch_done;
  logic              wdog_hit;

  logic [3:0]        sel_cmd;
  logic [BA_W-1:0]   sel_ba;
  logic [ADDR_W-1:0] sel_addr;
  logic [DQ_W-1:0]   sel_data;
  logic              sel_oe;

  // First pending channel at or after rr_ptr, wrapping at NUM_CH.
  always_comb begin
    rr_found = 1'b0;
    rr_sel   = '0;
    rr_idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rr_idx = {1'b0, rr_ptr} + (CH_W+1)'(i);
      if (rr_idx >= (CH_W+1)'(NUM_CH)) rr_idx = rr_idx - (CH_W+1)'(NUM_CH);
      if (!rr_found && ch_pend[rr_idx[CH_W-1:0]]) begin
        rr_found = 1'b1;
        rr_sel   = rr_idx[CH_W-1:0];
      end
    end
  end

  assign rr_next = (rr_sel == CH_LAST) ? '0 : rr_sel + CH_W'(1);

  // Sticky request capture; the granted source's bit is dropped on grant entry.
  always_comb begin
    aref_pend_nxt = aref_pend | aref_req_i;
    ch_pend_nxt   = ch_pend | ch_req_i;
    if (state == S_INIT) begin
      aref_pend_nxt = 1'b0;
      ch_pend_nxt   = '0;
    end else if (state == S_IDLE) begin
      if (aref_pend) aref_pend_nxt = 1'b0;
      else if (rr_found) ch_pend_nxt[rr_sel] = 1'b0;
    end
  end

  assign ch_done  = ch_end_i[cur_ch];
  assign wdog_hit = (WDOG_CYC != 0) && (wdog_cnt == WD_LAST);

  assign sel_cmd  = ch_cmd_i[4*cur_ch +: 4];
  assign sel_ba   = ch_ba_i[BA_W*cur_ch +: BA_W];
  assign sel_addr = ch_addr_i[ADDR_W*cur_ch +: ADDR_W];
  assign sel_data = ch_data_i[DQ_W*cur_ch +: DQ_W];
  assign sel_oe   = ch_dq_en_i[cur_ch];

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state       <= S_INIT;
      cur_ch      <= '0;
      rr_ptr      <= '0;
      aref_pend   <= 1'b0;
      ch_pend     <= '0;
      wdog_cnt    <= '0;
      aref_en_o   <= 1'b0;
      ch_en_o     <= '0;
      wdog_err_o  <= 1'b0;
      sdram_cke_o <= 1'b0;
    end else begin
      sdram_cke_o <= 1'b1;
      wdog_err_o  <= 1'b0;
      aref_pend   <= aref_pend_nxt;
      ch_pend     <= ch_pend_nxt;
      case (state)
        S_INIT: begin
          if (init_end_i) state <= S_IDLE;
        end
        S_IDLE: begin
          if (aref_pend) begin
            state     <= S_AREF;
            aref_en_o <= 1'b1;
          end else if (rr_found) begin
            state    <= S_CH;
            cur_ch   <= rr_sel;
            ch_en_o  <= NUM_CH'(1) << rr_sel;
            rr_ptr   <= rr_next;
            wdog_cnt <= '0;
          end
        end
        S_AREF: begin
          if (aref_end_i) begin
            state     <= S_IDLE;
            aref_en_o <= 1'b0;
          end
        end
        S_CH: begin
          // A genuine end in the expiry cycle wins, so no error is flagged.
          if (ch_done || wdog_hit) begin
            state      <= S_IDLE;
            ch_en_o    <= '0;
            wdog_err_o <= !ch_done;
          end else begin
            wdog_cnt <= wdog_cnt + WD_W'(1);
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

  // Pins reflect the bus owned in the previous cycle.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      {sdram_cs_n_o, sdram_ras_n_o, sdram_cas_n_o, sdram_we_n_o} <= CMD_NOP;
      sdram_ba_o    <= '1;
      sdram_addr_o  <= '1;
      sdram_dq_o    <= '0;
      sdram_dq_oe_o <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          {sdram_cs_n_o, sdram_ras_n_o, sdram_cas_n_o, sdram_we_n_o} <= init_cmd_i;
          sdram_ba_o    <= init_ba_i;
          sdram_addr_o  <= init_addr_i;
          sdram_dq_o    <= '0;
          sdram_dq_oe_o <= 1'b0;
        end
        S_AREF: begin
          {sdram_cs_n_o, sdram_ras_n_o, sdram_cas_n_o, sdram_we_n_o} <= aref_cmd_i;
          sdram_ba_o    <= aref_ba_i;
          sdram_addr_o  <= aref_addr_i;
          sdram_dq_o    <= '0;
          sdram_dq_oe_o <= 1'b0;
        end
        S_CH: begin
          {sdram_cs_n_o, sdram_ras_n_o, sdram_cas_n_o, sdram_we_n_o} <= sel_cmd;
          sdram_ba_o    <= sel_ba;
          sdram_addr_o  <= sel_addr;
          sdram_dq_o    <= sel_oe ? sel_data : '0;
          sdram_dq_oe_o <= sel_oe;
        end
        default: begin
          {sdram_cs_n_o, sdram_ras_n_o, sdram_cas_n_o, sdram_we_n_o} <= CMD_NOP;
          sdram_ba_o    <= '1;
          sdram_addr_o  <= '1;
          sdram_dq_o    <= '0;
          sdram_dq_oe_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
